channel_ocm_dp_ram: RTL and testbench
=====================================

# channel_ocm_dp_ram

Parametrised dual-port on-chip memory for the SERDES channel model. It holds channel coefficients and sample buffers shared between the NIOS data master and the channel datapath. It generalises the fixed 64-bit/8960-word channel OCM in four ways: configurable width and depth, pipelined reads with `readdatavalid`, defined collision and read-during-write behaviour, and a hardware clear engine that zero-fills the array between simulation runs. Both ports run on a single clock.

## Interface
Parameters:
- `DATA_W`, 64: data width in bits; must be a multiple of 8. `BE_W = DATA_W/8`.
- `ADDR_W`, 14: address width.
- `DEPTH`, 8960: number of words; must be ≤ 2^ADDR_W.
- `OUT_REG`, 0: 1 adds an output register, so read latency becomes 2.
- `INIT_FILE`, "OCM_config/channel_ocm_hex.hex": hex image loaded at elaboration.

Ports (the suffix `x` stands for `a` or `b`; every per-port signal exists once for each port):
- `clk` in 1: the single clock for both ports.
- `reset_n` in 1: synchronous, active-low reset.
- `clken` in 1: global clock enable.
- `reset_req` in 1: access inhibit, same effect as `clken`=0.
- `address_x` in ADDR_W: word address.
- `byteenable_x` in BE_W: byte lane enables for writes.
- `chipselect_x` in 1: port select.
- `read_x` in 1: read request.
- `write_x` in 1: write request.
- `writedata_x` in DATA_W: write data.
- `readdata_x` out DATA_W: read data.
- `readdatavalid_x` out 1: one-cycle pulse when `readdata_x` is valid.
- `clear` in 1: one-cycle pulse that starts the zero-fill.
- `busy` out 1: high while the clear engine runs.
- `collision_cnt` out 16: saturating count of write-write collisions.

## Operation
- An access is accepted on a port when `en = clken & ~reset_req & ~busy & chipselect_x` is true.
- Accepted write:
  - Updates only the byte lanes with `byteenable_x`=1.
  - Addresses ≥ DEPTH are dropped silently.
- Accepted read:
  - Enters a read pipeline of depth `1+OUT_REG`.
  - Addresses ≥ DEPTH return all zeros, and `readdatavalid_x` still pulses.
- `read_x` and `write_x` both high on the same port:
  - Both are accepted.
  - The read returns the newly merged word (write-first).
- Mixed-port, one port reads the address the other port writes in the same cycle: the read returns the old word.
- Write-write collision (both ports write the same in-range address in the same cycle):
  - Per byte lane, port A wins where both ports enable the lane.
  - Lanes enabled by only one port take that port's data.
  - `collision_cnt` increments, saturating at 16'hFFFF.
- `readdata_x` holds its last value between valid pulses.
- Pipeline control:
  - When `clken`=0 or `reset_req`=1, all pipeline registers and the clear FSM freeze.
  - `readdatavalid_x` is forced to 0 in every cycle where `clken`=0.
- Clear FSM:
  - States are IDLE and CLEAR.
  - IDLE → CLEAR when `clear`=1: the internal pointer loads 0 and `busy` rises on the next cycle.
  - In CLEAR, each enabled cycle writes zero at the pointer and increments it.
  - After writing DEPTH-1 the FSM returns to IDLE, and `busy` falls in the cycle after that final write.
  - `clear` is ignored while in CLEAR.
  - Port requests during `busy` are dropped; no writes occur and no valid pulses are produced.
  - Reads already in the pipeline when `busy` rises still complete.
- Reset (`reset_n`=0 at a clock edge):
  - FSM goes to IDLE, the pipelines are flushed, and the clear pointer goes to 0.
  - Memory contents are not altered. A reset in the middle of a clear leaves the array partially cleared.

## Timing
- Reset values: `readdata_x`=0, `readdatavalid_x`=0, `busy`=0, `collision_cnt`=0.
- Read latency:
  - OUT_REG=0: data and valid appear in the cycle after acceptance.
  - OUT_REG=1: data and valid appear 2 cycles after acceptance.
- Throughput is one read and/or one write per port per cycle. There is no backpressure; the requester must sample `busy`.
- A write is visible to a read on the other port accepted in the following cycle.
- A clear takes exactly DEPTH enabled cycles. Cycles with `clken`=0 extend it one-for-one.

## Configuration
- Macro: `OCM_COLLISION_CNT_EN`.
- Defined: the collision counter is implemented as described above.
- Undefined:
  - No counter logic is built and `collision_cnt` is tied to 0.
  - Collision data resolution is unchanged (port A priority per byte lane).

## Test plan
- Read latency, OUT_REG=0, DEPTH=8960:
  - Stimulus: port A writes 64'h0123_4567_89AB_CDEF to address 5 with `byteenable`=8'hFF; next cycle port B reads address 5.
  - Required response: B valid one cycle later with that value.
  - Repeat with OUT_REG=1: required latency is 2 cycles.
- Byte-lane write-write collision:
  - Stimulus: both ports write address 10 in the same cycle; A writes all 1s with `byteenable`=8'h0F, B writes all 0s with `byteenable`=8'hFF.
  - Required response: readback 64'h0000_0000_FFFF_FFFF; `collision_cnt`=1 with the macro defined, 0 without it.
- Read-during-write:
  - Stimulus: address 3 holds 0. In the same cycle, port A reads and writes address 3 with 64'h55 (`byteenable`=8'hFF), and port B reads address 3.
  - Required response: A returns 64'h55; B returns 0.
- Clear with stall, DEPTH=16:
  - Stimulus: pulse `clear`, hold `clken`=0 for 3 cycles mid-run.
  - Required response: `busy` high for exactly 19 cycles, all words read back 0, and a port A write issued during `busy` has no effect.
- Reset in the middle of a clear:
  - Stimulus: assert `reset_n`=0 after 4 clear writes with DEPTH=16.
  - Required response: `busy`=0; words 0–3 are zero, words 4–15 keep their INIT_FILE values; `readdatavalid_x`=0.
- Out-of-range access:
  - Stimulus: with DEPTH=8960, write to address 9000, then read address 9000.
  - Required response: valid pulse with data 0; no in-range word is modified.

Source files
------------

// File: rtl/channel_ocm_dp_ram.sv
// Dual-port channel OCM with pipelined reads, byte-lane collision resolution and a zero-fill engine.
// Optional collision counter: define OCM_COLLISION_CNT_EN.
module channel_ocm_dp_ram #(
  parameter int    DATA_W    = 64,
  parameter int    ADDR_W    = 14,
  parameter int    DEPTH     = 8960,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "OCM_config/channel_ocm_hex.hex",
  localparam int   BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [BE_W-1:0]   byteenable_a,
  input  logic              chipselect_a,
  input  logic              read_a,
  input  logic              write_a,
  input  logic [DATA_W-1:0] writedata_a,
  output logic [DATA_W-1:0] readdata_a,
  output logic              readdatavalid_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [BE_W-1:0]   byteenable_b,
  input  logic              chipselect_b,
  input  logic              read_b,
  input  logic              write_b,
  input  logic [DATA_W-1:0] writedata_b,
  output logic [DATA_W-1:0] readdata_b,
  output logic              readdatavalid_b,
  input  logic              clear,
  output logic              busy,
  output logic [15:0]       collision_cnt
);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STAGES = 1 + ((OUT_REG != 0) ? 1 : 0);

  typedef enum logic {IDLE, CLEAR} state_t;

  // The device flow attaches the init image to the array through this attribute.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              run;

  // Index 0 is port A, index 1 is port B.
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][IDX_W-1:0]  idx;
  logic [1:0][BE_W-1:0]   be;
  logic [1:0][DATA_W-1:0] wdata, wmask, old, rword, rdata;
  logic [1:0]             cs, rd_req, wr_req, en, in_rng, wr, rd, rvalid;

  assign run    = clken & ~reset_req & reset_n;
  assign busy   = (state == CLEAR);
  assign addr   = {address_b, address_a};
  assign be     = {byteenable_b, byteenable_a};
  assign wdata  = {writedata_b, writedata_a};
  assign cs     = {chipselect_b, chipselect_a};
  assign rd_req = {read_b, read_a};
  assign wr_req = {write_b, write_a};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][DATA_W-1:0] dat_pipe;

    assign en[p]     = run & ~busy & cs[p];
    assign in_rng[p] = 32'(addr[p]) < DEPTH;
    assign idx[p]    = addr[p][IDX_W-1:0];
    assign wr[p]     = en[p] & wr_req[p] & in_rng[p];
    assign rd[p]     = en[p] & rd_req[p];

    for (genvar b = 0; b < BE_W; b++) begin : g_mask
      assign wmask[p][8*b +: 8] = {8{be[p][b]}};
    end

    // Own-port write is merged into the read word (write-first); the other port sees the old word.
    always_comb begin
      old[p]   = in_rng[p] ? mem[idx[p]] : '0;
      rword[p] = old[p];
      if (wr[p] && rd[p]) rword[p] = (old[p] & ~wmask[p]) | (wdata[p] & wmask[p]);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else if (run) begin
        vld_pipe[1] <= rd[p];
        if (rd[p]) dat_pipe[1] <= rword[p];
        for (int s = 2; s <= STAGES; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
        end
      end
    end

    // Masking with run makes a frozen result surface exactly once, on the cycle the pipe advances.
    assign rvalid[p] = vld_pipe[STAGES] & run;
    assign rdata[p]  = dat_pipe[STAGES];
  end

  assign readdata_a      = rdata[0];
  assign readdata_b      = rdata[1];
  assign readdatavalid_a = rvalid[0];
  assign readdatavalid_b = rvalid[1];

  // Port B lanes are written first so port A overrides any lane both ports enable.
  always_ff @(posedge clk) begin
    if (busy && run) mem[ptr[IDX_W-1:0]] <= '0;
    for (int p = 1; p >= 0; p--)
      for (int b = 0; b < BE_W; b++)
        if (wr[p] && be[p][b]) mem[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else if (run) begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (clear) begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
      CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef OCM_COLLISION_CNT_EN
  logic [15:0] coll_q;

  always_ff @(posedge clk) begin
    if (!reset_n) coll_q <= '0;
    else if (run && wr[0] && wr[1] && addr[0] == addr[1] && coll_q != 16'hFFFF)
      coll_q <= coll_q + 16'd1;
  end

  assign collision_cnt = coll_q;
`else
  assign collision_cnt = '0;
`endif
endmodule

// File: tb/tb_channel_ocm_dp_ram.sv
// Scoreboard bench for channel_ocm_dp_ram: instance 0 is DEPTH=8960/OUT_REG=0, instance 1 is DEPTH=16/OUT_REG=1.
// Streams: 0=d0 port A, 1=d0 port B, 2=d1 port A, 3=d1 port B.
module tb_channel_ocm_dp_ram;
  typedef struct {
    logic [63:0] d;
    int          due;
  } sb_t;

`ifdef OCM_COLLISION_CNT_EN
  localparam logic [15:0] COLL_EXP = 16'd1;
`else
  localparam logic [15:0] COLL_EXP = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken[2], reset_req[2], clear[2], busy[2];
  logic [15:0] coll[2];
  logic        cs[4], rdq[4], wrq[4], rv[4];
  logic [13:0] addr[4];
  logic [7:0]  be[4];
  logic [63:0] wd[4], rdata[4];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  nb;
  sb_t sbq[4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  channel_ocm_dp_ram #(.DEPTH(8960), .OUT_REG(0)) d0 (
    .clk(clk), .reset_n(reset_n), .clken(clken[0]), .reset_req(reset_req[0]),
    .address_a(addr[0]), .byteenable_a(be[0]), .chipselect_a(cs[0]), .read_a(rdq[0]),
    .write_a(wrq[0]), .writedata_a(wd[0]), .readdata_a(rdata[0]), .readdatavalid_a(rv[0]),
    .address_b(addr[1]), .byteenable_b(be[1]), .chipselect_b(cs[1]), .read_b(rdq[1]),
    .write_b(wrq[1]), .writedata_b(wd[1]), .readdata_b(rdata[1]), .readdatavalid_b(rv[1]),
    .clear(clear[0]), .busy(busy[0]), .collision_cnt(coll[0]));

  channel_ocm_dp_ram #(.DEPTH(16), .OUT_REG(1)) d1 (
    .clk(clk), .reset_n(reset_n), .clken(clken[1]), .reset_req(reset_req[1]),
    .address_a(addr[2]), .byteenable_a(be[2]), .chipselect_a(cs[2]), .read_a(rdq[2]),
    .write_a(wrq[2]), .writedata_a(wd[2]), .readdata_a(rdata[2]), .readdatavalid_a(rv[2]),
    .address_b(addr[3]), .byteenable_b(be[3]), .chipselect_b(cs[3]), .read_b(rdq[3]),
    .write_b(wrq[3]), .writedata_b(wd[3]), .readdata_b(rdata[3]), .readdatavalid_b(rv[3]),
    .clear(clear[1]), .busy(busy[1]), .collision_cnt(coll[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle();
    for (int s = 0; s < 4; s++) begin
      cs[s] = 1'b0; rdq[s] = 1'b0; wrq[s] = 1'b0;
    end
    clear[0] = 1'b0; clear[1] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int s, input logic [13:0] a, input logic [63:0] d, input logic [7:0] m);
    cs[s] = 1'b1; wrq[s] = 1'b1; addr[s] = a; wd[s] = d; be[s] = m;
  endtask

  // lat_extra covers cycles where the pipe is deliberately stalled after acceptance.
  task automatic rd(input int s, input logic [13:0] a, input logic [63:0] exp, input int lat_extra);
    sb_t e;
    cs[s] = 1'b1; rdq[s] = 1'b1; addr[s] = a;
    e.d   = exp;
    e.due = cyc + ((s < 2) ? 1 : 2) + lat_extra;
    sbq[s].push_back(e);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 4; s++) begin
      if (sbq[s].size() != 0 && sbq[s][0].due == cyc) begin
        chk($sformatf("valid%0d", s), 64'(rv[s]), 64'd1);
        chk($sformatf("data%0d", s), rdata[s], sbq[s][0].d);
        void'(sbq[s].pop_front());
      end else if (rv[s]) begin
        chk($sformatf("spurious_valid%0d", s), 64'(rv[s]), 64'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clken[i] = 1'b1; reset_req[i] = 1'b0; clear[i] = 1'b0;
    end
    for (int s = 0; s < 4; s++) begin
      addr[s] = '0; be[s] = '0; wd[s] = '0;
    end
    idle();
    tick(); tick();
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst_rdata%0d", s), rdata[s], 64'd0);
      chk($sformatf("rst_valid%0d", s), 64'(rv[s]), 64'd0);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
      chk($sformatf("rst_coll%0d", i), 64'(coll[i]), 64'd0);
    end
    reset_n = 1'b1;
    tick();

    // Write on A, read on B the next cycle; latency 1 on d0, 2 on d1.
    wr(0, 14'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    wr(2, 14'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    tick();
    rd(1, 14'd5, 64'h0123_4567_89AB_CDEF, 0);
    rd(3, 14'd5, 64'h0123_4567_89AB_CDEF, 0);
    tick(); tick(); tick(); tick();
    chk("hold_b0", rdata[1], 64'h0123_4567_89AB_CDEF);
    chk("hold_b1", rdata[3], 64'h0123_4567_89AB_CDEF);

    // Byte-lane write-write collision.
    wr(0, 14'd10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    wr(1, 14'd10, 64'h0, 8'hFF);
    tick();
    rd(0, 14'd10, 64'h0000_0000_FFFF_FFFF, 0);
    tick();
    chk("coll_cnt", 64'(coll[0]), 64'(COLL_EXP));

    // Partial byte-enable merge.
    wr(0, 14'd7, 64'h1111_1111_1111_1111, 8'hFF);
    tick();
    wr(1, 14'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81);
    tick();
    rd(0, 14'd7, 64'hAA11_1111_1111_11AA, 0);
    tick();

    // Read-during-write: own port write-first, other port old data.
    wr(0, 14'd3, 64'h0, 8'hFF);
    tick();
    wr(0, 14'd3, 64'h55, 8'hFF);
    rd(0, 14'd3, 64'h55, 0);
    rd(1, 14'd3, 64'h0, 0);
    tick();
    rd(1, 14'd3, 64'h55, 0);
    tick();

    // clken=0 during the return cycle delays the valid by one cycle.
    rd(0, 14'd5, 64'h0123_4567_89AB_CDEF, 1);
    tick();
    clken[0] = 1'b0;
    tick();
    clken[0] = 1'b1;
    tick();

    // Out-of-range write dropped, read returns zero with a valid pulse.
    wr(0, 14'd9000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick();
    rd(0, 14'd9000, 64'h0, 0);
    tick();
    rd(0, 14'd5, 64'h0123_4567_89AB_CDEF, 0);
    rd(1, 14'd10, 64'h0000_0000_FFFF_FFFF, 0);
    tick();
    tick();

    // Clear with a 3-cycle stall on d1.
    for (int i = 0; i < 16; i++) begin
      wr(2, 14'(i), 64'hA5A5_0000_0000_0000 | 64'(i + 1), 8'hFF);
      tick();
    end
    clear[1] = 1'b1;
    tick();
    nb = 0;
    for (int k = 0; k < 40 && busy[1]; k++) begin
      nb++;
      clken[1] = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
      if (k == 2) begin
        wr(2, 14'd2, 64'hDEAD_BEEF, 8'hFF);
        cs[3] = 1'b1; rdq[3] = 1'b1; addr[3] = 14'd2;
      end
      tick();
    end
    clken[1] = 1'b1;
    chk("busy_cycles", 64'(nb), 64'd19);
    for (int i = 0; i < 16; i++) begin
      rd(3, 14'(i), 64'h0, 0);
      tick();
    end
    tick(); tick();

    // Reset after four clear writes leaves words 4..15 intact.
    for (int i = 0; i < 16; i++) begin
      wr(2, 14'(i), 64'h100 + 64'(i), 8'hFF);
      tick();
    end
    clear[1] = 1'b1;
    tick();
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    chk("rst_mid_busy", 64'(busy[1]), 64'd0);
    chk("rst_mid_valid_a", 64'(rv[2]), 64'd0);
    chk("rst_mid_valid_b", 64'(rv[3]), 64'd0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      rd(3, 14'(i), (i < 4) ? 64'h0 : 64'h100 + 64'(i), 0);
      tick();
    end

    repeat (5) tick();
    for (int s = 0; s < 4; s++) chk($sformatf("drain%0d", s), 64'(sbq[s].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
